// File: rtl/wrr_pop_scheduler_pkg.sv
// Shared types and helpers for the weighted round-robin pop scheduler.
package wrr_pop_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StServe = 2'd2
    } state_e;

    // Index width that stays at least 1 bit for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_pop_scheduler_if.sv
// FIFO-bank / output-mux side signals of the scheduler, bundled with modports.
interface wrr_pop_scheduler_if
    import wrr_pop_scheduler_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned MAX_WEIGHT     = 64
);
    localparam int unsigned W   = idx_width(MAX_WEIGHT);
    localparam int unsigned SEL = idx_width(QUEUE_QUANTITY);

    logic                        enb;
    logic [QUEUE_QUANTITY*W-1:0] pesos;
    logic [QUEUE_QUANTITY-1:0]   buf_empty;
    logic                        out_ready;
    logic [QUEUE_QUANTITY-1:0]   pop;
    logic [SEL-1:0]              selector;
    logic                        selector_enb;
    // FIFO read word on its way to the mux; the scheduler never looks at it.
    logic [DATA_BITS-1:0]        data;

    modport master (
        input  enb, pesos, buf_empty, out_ready,
        output pop, selector, selector_enb
    );

    modport slave (
        output enb, pesos, buf_empty, out_ready, data,
        input  pop, selector, selector_enb
    );

endinterface

// File: rtl/wrr_pop_scheduler_rr_next_eligible.sv
// Circular priority encoder: first eligible index strictly after ptr, wrapping around.
module wrr_pop_scheduler_rr_next_eligible #(
    parameter int unsigned QUEUE_QUANTITY = 4,
    parameter int unsigned SEL            = 2
) (
    input  logic [QUEUE_QUANTITY-1:0] eligible,
    input  logic [SEL-1:0]            ptr,
    output logic [SEL-1:0]            next,
    output logic                      found
);

    logic [SEL-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest eligible queue wins.
    always_comb begin
        next  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = QUEUE_QUANTITY; i >= 1; i--) begin
            idx = SEL'((int'(ptr) + i) % QUEUE_QUANTITY);
            if (eligible[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler: grants bursts of up to pesos[q] pops to each FIFO in turn.
module wrr_pop_scheduler
    import wrr_pop_scheduler_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = 4,
    parameter int unsigned MAX_WEIGHT     = 64
) (
    input logic               clk,
    input logic               rst,
    wrr_pop_scheduler_if.master bus
);

    localparam int unsigned W   = idx_width(MAX_WEIGHT);
    localparam int unsigned SEL = idx_width(QUEUE_QUANTITY);

    state_e                    fsm;
    logic [SEL-1:0]            ptr;
    logic [SEL-1:0]            cur;
    logic [W-1:0]              credit;
    logic [SEL-1:0]            selector;
    logic                      selector_enb;
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [QUEUE_QUANTITY-1:0] pop;
    logic [SEL-1:0]            next_q;
    logic [W-1:0]              next_weight;
    logic                      found;
    logic                      pop_any;

    always_comb begin
        eligible = '0;
        for (int q = 0; q < QUEUE_QUANTITY; q++) begin
            eligible[q] = !bus.buf_empty[q] && (bus.pesos[q*W +: W] != '0);
        end
    end

    wrr_pop_scheduler_rr_next_eligible #(
        .QUEUE_QUANTITY (QUEUE_QUANTITY),
        .SEL            (SEL)
    ) u_next (
        .eligible (eligible),
        .ptr      (ptr),
        .next     (next_q),
        .found    (found)
    );

    always_comb begin
        next_weight = bus.pesos[int'(next_q)*W +: W];
        pop_any     = (fsm == StServe) && bus.enb && bus.out_ready && !bus.buf_empty[cur];
        pop         = '0;
        pop[cur]    = pop_any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= StIdle;
            ptr          <= SEL'(QUEUE_QUANTITY - 1);
            cur          <= '0;
            credit       <= '0;
            selector     <= '0;
            selector_enb <= 1'b0;
        end else if (!bus.enb) begin
            selector_enb <= 1'b0;
        end else begin
            // Output stage lines up with the one-cycle FIFO read latency.
            selector_enb <= pop_any;
            if (pop_any) selector <= cur;
            unique case (fsm)
                StIdle: begin
                    if (|eligible) fsm <= StScan;
                end
                StScan: begin
                    if (found) begin
                        cur    <= next_q;
                        ptr    <= next_q;
                        credit <= next_weight;
                        fsm    <= StServe;
                    end else begin
                        fsm <= StIdle;
                    end
                end
                StServe: begin
                    // An emptied FIFO forfeits its remaining credit.
                    if (bus.buf_empty[cur]) begin
                        fsm <= StScan;
                    end else if (pop_any) begin
                        if (credit == W'(1)) fsm <= StScan;
                        else                 credit <= credit - W'(1);
                    end
                end
                default: fsm <= StIdle;
            endcase
        end
    end

    assign bus.pop          = pop;
    assign bus.selector     = selector;
    assign bus.selector_enb = selector_enb;

endmodule
